// File: rtl/pipeline_pkg.sv
// Shared constants and encodings for the 16-bit pipeline.
package pipeline_pkg;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 8;
  localparam int IMM8_W      = 8;
  localparam int REG_W       = 4;
  localparam int TIMEOUT_DEF = 15;

  // Data-memory access FSM
  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_e;

  // ALU operation codes (decoded in ID, consumed in EX)
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  // EX operand forward select: register file, M-stage value, W-stage value
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_e;
endpackage

// File: rtl/mem_access_ctrl.sv
// Data-memory handshake FSM with a bounded wait and a sticky timeout flag.
module mem_access_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
  output logic complete_o,
  output logic abort_o,
  output logic err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          req, abort;

  // Next state, wait counter and request. On the timeout cycle the request is
  // dropped so any ack arriving then is ignored and the access is abandoned.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (mem_op_i) begin
          req = 1'b1;
          if (!ack_i) begin
            state_d = MS_WAIT;
            cnt_d   = CW'(1);
          end
        end
      end
      MS_WAIT: begin
        if (!mem_op_i) begin
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_CNT) begin
          abort   = 1'b1;
          err_d   = 1'b1;
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else begin
          req = 1'b1;
          if (ack_i) begin
            state_d = MS_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = MS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req_o      = req;
  assign complete_o = req & ack_i;
  assign abort_o    = abort;
  assign stall_o    = mem_op_i & ~(req & ack_i) & ~abort;
  assign err_o      = err_q;
endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access, branch/jump redirect, M forward value, MEM/WB register.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int IMM8_WIDTH = IMM8_W,
  parameter int REG_WIDTH  = REG_W,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic [IMM8_WIDTH-1:0] imm8M_i,
  input  logic [REG_WIDTH-1:0]  WriteRegM_i,
  input  logic [DATA_WIDTH-1:0] alu_outM_i,
  input  logic                  RegWriteM_i,
  input  logic                  BranchM_i,
  input  logic                  MemReadM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MemToRegM_i,
  input  logic                  MovM_i,
  input  logic                  jumpM_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_mem_o,
  output logic                  pc_src_o,
  output logic [ADDR_WIDTH-1:0] pc_target_o,
  output logic                  flush_o,
  output logic [DATA_WIDTH-1:0] WBResultM_o,
  output logic                  RegWriteW_o,
  output logic [REG_WIDTH-1:0]  WriteRegW_o,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic                  mem_err_o
);
  logic mem_op, stall, complete, abort;
  logic take;

  logic                  RegWriteW_q, RegWriteW_d;
  logic [REG_WIDTH-1:0]  WriteRegW_q, WriteRegW_d;
  logic [DATA_WIDTH-1:0] ResultW_q,   ResultW_d;

  assign mem_op = MemReadM_i | MemWriteM_i;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .mem_op_i   (mem_op),
    .ack_i      (dmem_ack_i),
    .req_o      (dmem_req_o),
    .stall_o    (stall),
    .complete_o (complete),
    .abort_o    (abort),
    .err_o      (mem_err_o)
  );

  // A write wins when both read and write are flagged
  assign dmem_we_o    = MemWriteM_i;
  assign dmem_addr_o  = alu_outM_i[ADDR_WIDTH-1:0];
  assign dmem_wdata_o = WriteDataM_i;
  assign stall_mem_o  = stall;

  // M-stage forward value; load data is only available from W
  assign WBResultM_o = MovM_i ? {{(DATA_WIDTH-IMM8_WIDTH){1'b0}}, imm8M_i} : alu_outM_i;

  // Redirect: jump beats taken branch; held off while the stage is stalled
  always_comb begin
    take        = 1'b0;
    pc_target_o = PCM_i + ADDR_WIDTH'(imm8M_i);
    if (jumpM_i) begin
      take        = 1'b1;
      pc_target_o = ADDR_WIDTH'(imm8M_i);
    end else if (BranchM_i && (alu_outM_i == '0)) begin
      take = 1'b1;
    end
  end

  assign pc_src_o = take & ~stall;
  assign flush_o  = pc_src_o;

  // MEM/WB next value: bubble while stalled or when an access is abandoned
  always_comb begin
    RegWriteW_d = 1'b0;
    WriteRegW_d = '0;
    ResultW_d   = '0;
    if (!(stall || abort)) begin
      RegWriteW_d = RegWriteM_i;
      WriteRegW_d = WriteRegM_i;
      ResultW_d   = MemToRegM_i ? dmem_rdata_i : WBResultM_o;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW_q <= 1'b0;
      WriteRegW_q <= '0;
      ResultW_q   <= '0;
    end else begin
      RegWriteW_q <= RegWriteW_d;
      WriteRegW_q <= WriteRegW_d;
      ResultW_q   <= ResultW_d;
    end
  end

  assign RegWriteW_o = RegWriteW_q;
  assign WriteRegW_o = WriteRegW_q;
  assign ResultW_o   = ResultW_q;

  logic unused_complete;
  assign unused_complete = complete;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instructions.
module tb_mem_stage;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  PCM, imm8;
  logic [15:0] wdata, alu, rdata;
  logic [3:0]  wreg;
  logic        regw, br, mrd, mwr, m2r, mov, jmp, ack;
  logic        req, we, stall, pc_src, flush, RegWriteW, err;
  logic [7:0]  addr, target;
  logic [15:0] dwdata, WBResultM, ResultW;
  logic [3:0]  WriteRegW;

  int checks = 0;
  int failures = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .PCM_i(PCM), .WriteDataM_i(wdata), .imm8M_i(imm8),
    .WriteRegM_i(wreg), .alu_outM_i(alu), .RegWriteM_i(regw), .BranchM_i(br),
    .MemReadM_i(mrd), .MemWriteM_i(mwr), .MemToRegM_i(m2r), .MovM_i(mov), .jumpM_i(jmp),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(dwdata),
    .dmem_ack_i(ack), .dmem_rdata_i(rdata), .stall_mem_o(stall), .pc_src_o(pc_src),
    .pc_target_o(target), .flush_o(flush), .WBResultM_o(WBResultM), .RegWriteW_o(RegWriteW),
    .WriteRegW_o(WriteRegW), .ResultW_o(ResultW), .mem_err_o(err)
  );

  // Inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational outputs are sampled late in the cycle
  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    PCM = 0; imm8 = 0; wdata = 0; alu = 0; rdata = 0; wreg = 0;
    regw = 0; br = 0; mrd = 0; mwr = 0; m2r = 0; mov = 0; jmp = 0; ack = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    settle();
    checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL reset_regw got=%b exp=0", RegWriteW); end
    checks++; if (WriteRegW !== 4'h0) begin failures++; $display("FAIL reset_wreg got=%h exp=0", WriteRegW); end
    checks++; if (ResultW !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", ResultW); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if ({req, stall, pc_src} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {req, stall, pc_src}); end
    rst = 1'b0;
    tick();
  endtask

  // Reset while waiting on memory, then a late ack that must be ignored
  task automatic test_rst_wait();
    mrd = 1; m2r = 1; regw = 1; wreg = 4'h5; alu = 16'h0011; rdata = 16'h7777;
    settle();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rstw_stall0 got=%b exp=1", stall); end
    tick(); tick();
    rst = 1'b1; clear_inputs();
    tick();
    rst = 1'b0;
    settle();
    checks++; if ({req, stall, RegWriteW, err} !== 4'b0000) begin failures++; $display("FAIL rstw_after got=%b exp=0000", {req, stall, RegWriteW, err}); end
    checks++; if (ResultW !== 16'h0) begin failures++; $display("FAIL rstw_result got=%h exp=0", ResultW); end
    tick();
    ack = 1'b1; rdata = 16'hDEAD;
    settle();
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rstw_lateack_req got=%b exp=0", req); end
    tick();
    ack = 1'b0;
    settle();
    checks++; if ({RegWriteW, err} !== 2'b00) begin failures++; $display("FAIL rstw_lateack_wb got=%b exp=00", {RegWriteW, err}); end
    // FSM must be back in IDLE: a same-cycle ack completes without stalling
    mrd = 1; ack = 1;
    settle();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rstw_idle_stall got=%b exp=0", stall); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_load();
    mrd = 1; m2r = 1; regw = 1; wreg = 4'h3; alu = 16'h0020; rdata = 16'hBEEF;
    for (int c = 0; c <= 3; c++) begin
      ack = (c == 3);
      settle();
      checks++; if (req !== 1'b1) begin failures++; $display("FAIL load_req c=%0d got=%b exp=1", c, req); end
      checks++; if (stall !== (c < 3)) begin failures++; $display("FAIL load_stall c=%0d got=%b exp=%b", c, stall, (c < 3)); end
      tick();
      if (c < 3) begin
        checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL load_bubble c=%0d got=%b exp=0", c, RegWriteW); end
      end
    end
    checks++; if ({RegWriteW, WriteRegW, ResultW} !== {1'b1, 4'h3, 16'hBEEF}) begin
      failures++; $display("FAIL load_wb got=%b/%h/%h exp=1/3/beef", RegWriteW, WriteRegW, ResultW); end
    clear_inputs();
    tick();
  endtask

  task automatic test_store();
    mwr = 1; alu = 16'h5540; wdata = 16'h1234; ack = 1;
    settle();
    checks++; if ({req, we, stall} !== 3'b110) begin failures++; $display("FAIL store_ctl got=%b exp=110", {req, we, stall}); end
    checks++; if ({addr, dwdata} !== {8'h40, 16'h1234}) begin failures++; $display("FAIL store_bus got=%h/%h exp=40/1234", addr, dwdata); end
    tick();
    clear_inputs();
    settle();
    checks++; if ({req, stall, RegWriteW} !== 3'b000) begin failures++; $display("FAIL store_after got=%b exp=000", {req, stall, RegWriteW}); end
    tick();
  endtask

  task automatic test_timeout();
    mrd = 1; m2r = 1; regw = 1; wreg = 4'h9; rdata = 16'h4444;
    for (int c = 0; c <= TO; c++) begin
      settle();
      checks++; if (stall !== (c < TO)) begin failures++; $display("FAIL to_stall c=%0d got=%b exp=%b", c, stall, (c < TO)); end
      checks++; if (req !== (c < TO)) begin failures++; $display("FAIL to_req c=%0d got=%b exp=%b", c, req, (c < TO)); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_early c=%0d got=%b exp=0", c, err); end
      tick();
    end
    exp_err = 1'b1;
    checks++; if ({err, RegWriteW, WriteRegW, ResultW} !== {1'b1, 1'b0, 4'h0, 16'h0}) begin
      failures++; $display("FAIL to_abort got=%b/%b/%h/%h exp=1/0/0/0", err, RegWriteW, WriteRegW, ResultW); end
    clear_inputs();
    tick(); tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", err); end
  endtask

  task automatic test_branch();
    br = 1; PCM = 8'hF8; imm8 = 8'h10; alu = 16'h0000;
    settle();
    checks++; if ({pc_src, flush, target} !== {2'b11, 8'h08}) begin failures++; $display("FAIL br_taken got=%b%b/%h exp=11/08", pc_src, flush, target); end
    tick();
    alu = 16'h0001;
    settle();
    checks++; if ({pc_src, flush} !== 2'b00) begin failures++; $display("FAIL br_not got=%b exp=00", {pc_src, flush}); end
    tick();
    jmp = 1; alu = 16'h0000; imm8 = 8'h33;
    settle();
    checks++; if ({pc_src, target} !== {1'b1, 8'h33}) begin failures++; $display("FAIL jmp_prio got=%b/%h exp=1/33", pc_src, target); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_mov();
    mov = 1; imm8 = 8'hA5; wreg = 4'h7; regw = 1; alu = 16'h9999;
    settle();
    checks++; if (WBResultM !== 16'h00A5) begin failures++; $display("FAIL mov_m got=%h exp=00a5", WBResultM); end
    tick();
    checks++; if ({RegWriteW, WriteRegW, ResultW} !== {1'b1, 4'h7, 16'h00A5}) begin
      failures++; $display("FAIL mov_w got=%b/%h/%h exp=1/7/00a5", RegWriteW, WriteRegW, ResultW); end
    clear_inputs();
    tick();
  endtask

  // Random instructions; memory answers after L wait cycles (abandoned if L >= TO)
  task automatic test_random();
    int L, last;
    logic memop, aborted, taken, exp_stall, exp_req;
    logic [7:0]  exp_tgt;
    logic [15:0] exp_res;
    for (int n = 0; n < 80; n++) begin
      PCM = 8'($urandom); imm8 = 8'($urandom); wdata = 16'($urandom);
      alu = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      rdata = 16'($urandom); wreg = 4'($urandom);
      regw = 1'($urandom); br = 1'($urandom); jmp = ($urandom_range(0, 3) == 0);
      mrd = 1'($urandom); mwr = ($urandom_range(0, 2) == 0);
      m2r = 1'($urandom); mov = 1'($urandom);
      memop = mrd | mwr;
      L = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 4);
      aborted = memop && (L >= TO);
      last = memop ? ((L < TO) ? L : TO) : 0;
      taken = jmp || (br && alu == 16'h0);
      exp_tgt = jmp ? imm8 : 8'(PCM + imm8);
      exp_res = m2r ? rdata : (mov ? {8'h00, imm8} : alu);
      for (int c = 0; c <= last; c++) begin
        ack = memop ? (c == L) : 1'($urandom);
        exp_stall = memop && (c < last);
        exp_req = memop && (c <= L) && (c < TO);
        settle();
        checks++; if (stall !== exp_stall) begin failures++; $display("FAIL rnd_stall n=%0d c=%0d got=%b exp=%b", n, c, stall, exp_stall); end
        checks++; if (req !== exp_req) begin failures++; $display("FAIL rnd_req n=%0d c=%0d got=%b exp=%b", n, c, req, exp_req); end
        checks++; if (pc_src !== (taken && !exp_stall)) begin failures++; $display("FAIL rnd_pcsrc n=%0d c=%0d got=%b exp=%b", n, c, pc_src, taken && !exp_stall); end
        if (taken) begin
          checks++; if (target !== exp_tgt) begin failures++; $display("FAIL rnd_target n=%0d got=%h exp=%h", n, target, exp_tgt); end
        end
        if (memop) begin
          checks++; if ({we, addr, dwdata} !== {mwr, alu[7:0], wdata}) begin failures++; $display("FAIL rnd_bus n=%0d got=%b/%h/%h exp=%b/%h/%h", n, we, addr, dwdata, mwr, alu[7:0], wdata); end
        end
        tick();
        if (c < last) begin
          checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL rnd_bubble n=%0d c=%0d got=%b exp=0", n, c, RegWriteW); end
        end
      end
      if (aborted) exp_err = 1'b1;
      if (aborted) begin
        checks++; if ({RegWriteW, WriteRegW, ResultW} !== 21'h0) begin failures++; $display("FAIL rnd_abort_wb n=%0d got=%b/%h/%h exp=0/0/0", n, RegWriteW, WriteRegW, ResultW); end
      end else begin
        checks++; if ({RegWriteW, WriteRegW, ResultW} !== {regw, wreg, exp_res}) begin
          failures++; $display("FAIL rnd_wb n=%0d got=%b/%h/%h exp=%b/%h/%h", n, RegWriteW, WriteRegW, ResultW, regw, wreg, exp_res); end
      end
      checks++; if (err !== exp_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err, exp_err); end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_rst_wait();
    test_load();
    test_store();
    test_branch();
    test_mov();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
